// File: rtl/riscv_csr_ctrl.sv
// riscv_csr_ctrl: machine-mode CSR file and sequencer.
// Owns mstatus/mtvec/mscratch/mepc/mcause. Runs CSR read-modify-write
// operations (W/S/C) and issues PC redirects on trap entry and mret.
// Arbitration in IDLE: trap_req > mret_req > csr_req.
//
// Optional feature: define RISCV_CSR_MCYCLE_EN to add a 64-bit mcycle
// counter readable at 0xB00 (low word) and 0xB80 (high word). Without it,
// those addresses decode as illegal.
module riscv_csr_ctrl #(
  parameter int unsigned              WORD_LENGTH = 32,
  parameter logic [WORD_LENGTH-1:0]   MTVEC_RESET = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   csr_req,
  input  logic [1:0]             csr_fun,
  input  logic [11:0]            csr_addr,
  input  logic [WORD_LENGTH-1:0] csr_wdata,
  output logic                   csr_ack,
  output logic [WORD_LENGTH-1:0] csr_rdata,
  output logic                   csr_illegal,
  input  logic                   trap_req,
  input  logic [WORD_LENGTH-1:0] trap_cause,
  input  logic [WORD_LENGTH-1:0] trap_pc,
  input  logic                   mret_req,
  output logic                   redirect_valid,
  output logic [WORD_LENGTH-1:0] redirect_pc,
  output logic                   busy
);

  localparam int unsigned WL     = WORD_LENGTH;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned FUN_W  = 2;

  localparam logic [FUN_W-1:0] CSR_NONE = 2'b00;
  localparam logic [FUN_W-1:0] CSR_W    = 2'b01;
  localparam logic [FUN_W-1:0] CSR_S    = 2'b10;
  localparam logic [FUN_W-1:0] CSR_C    = 2'b11;

  localparam logic [ADDR_W-1:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [ADDR_W-1:0] ADDR_MTVEC    = 12'h305;
  localparam logic [ADDR_W-1:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [ADDR_W-1:0] ADDR_MEPC     = 12'h341;
  localparam logic [ADDR_W-1:0] ADDR_MCAUSE   = 12'h342;
`ifdef RISCV_CSR_MCYCLE_EN
  localparam logic [ADDR_W-1:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [ADDR_W-1:0] ADDR_MCYCLEH  = 12'hB80;
`endif

  // Word-aligned mask for mtvec/mepc
  localparam logic [WL-1:0] ALIGN_MASK = ~WL'(3);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_TRAP,
    ST_RET
  } state_t;

  state_t state_q, state_d;

  // Latched CSR op and RD-stage results
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [FUN_W-1:0]  fun_q,   fun_d;
  logic [WL-1:0]     wdata_q, wdata_d;
  logic [WL-1:0]     old_q,   old_d;
  logic              legal_q, legal_d;

  // Architectural state; mstatus keeps only MIE and MPIE
  logic              mie_q,      mie_d;
  logic              mpie_q,     mpie_d;
  logic [WL-1:0]     mtvec_q,    mtvec_d;
  logic [WL-1:0]     mscratch_q, mscratch_d;
  logic [WL-1:0]     mepc_q,     mepc_d;
  logic [WL-1:0]     mcause_q,   mcause_d;
`ifdef RISCV_CSR_MCYCLE_EN
  logic [63:0]       mcycle_q,   mcycle_d;
`endif

  // Registered outputs
  logic              csr_ack_d;
  logic [WL-1:0]     csr_rdata_d;
  logic              csr_illegal_d;
  logic              redirect_valid_d;
  logic [WL-1:0]     redirect_pc_d;

  // Read mux and legality decode for the latched address
  logic [WL-1:0] rd_val;
  logic          rd_legal;

  // Read-modify-write result of the latched op
  logic [WL-1:0] wr_val;
  logic          do_write;

  assign busy = (state_q != ST_IDLE);

  // CSR read decode
  always_comb begin
    rd_val   = '0;
    rd_legal = 1'b0;
    case (addr_q)
      ADDR_MSTATUS: begin
        rd_legal  = 1'b1;
        rd_val[3] = mie_q;
        rd_val[7] = mpie_q;
      end
      ADDR_MTVEC: begin
        rd_legal = 1'b1;
        rd_val   = mtvec_q;
      end
      ADDR_MSCRATCH: begin
        rd_legal = 1'b1;
        rd_val   = mscratch_q;
      end
      ADDR_MEPC: begin
        rd_legal = 1'b1;
        rd_val   = mepc_q;
      end
      ADDR_MCAUSE: begin
        rd_legal = 1'b1;
        rd_val   = mcause_q;
      end
`ifdef RISCV_CSR_MCYCLE_EN
      ADDR_MCYCLE: begin
        rd_legal = 1'b1;
        rd_val   = WL'(mcycle_q[31:0]);
      end
      ADDR_MCYCLEH: begin
        rd_legal = 1'b1;
        rd_val   = WL'(mcycle_q[63:32]);
      end
`endif
      default: begin
        rd_legal = 1'b0;
        rd_val   = '0;
      end
    endcase
  end

  // CSR ALU on the value latched in RD
  always_comb begin
    wr_val = old_q;
    case (fun_q)
      CSR_W:   wr_val = wdata_q;
      CSR_S:   wr_val = old_q | wdata_q;
      CSR_C:   wr_val = old_q & ~wdata_q;
      default: wr_val = old_q;
    endcase
  end

  assign do_write = (state_q == ST_WR) && legal_q && (fun_q != CSR_NONE);

  // Next-state, CSR update and output logic
  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    fun_d            = fun_q;
    wdata_d          = wdata_q;
    old_d            = old_q;
    legal_d          = legal_q;
    mie_d            = mie_q;
    mpie_d           = mpie_q;
    mtvec_d          = mtvec_q;
    mscratch_d       = mscratch_q;
    mepc_d           = mepc_q;
    mcause_d         = mcause_q;
`ifdef RISCV_CSR_MCYCLE_EN
    mcycle_d         = mcycle_q + 64'd1;
`endif
    csr_ack_d        = 1'b0;
    csr_rdata_d      = '0;
    csr_illegal_d    = 1'b0;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc;

    case (state_q)
      ST_IDLE: begin
        if (trap_req) begin
          state_d          = ST_TRAP;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = mtvec_q & ALIGN_MASK;
        end else if (mret_req) begin
          state_d          = ST_RET;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = mepc_q;
        end else if (csr_req) begin
          state_d = ST_RD;
          addr_d  = csr_addr;
          fun_d   = csr_fun;
          wdata_d = csr_wdata;
        end
      end

      ST_RD: begin
        // A trap here abandons the op; the requester re-issues it later
        if (trap_req) begin
          state_d          = ST_TRAP;
          redirect_valid_d = 1'b1;
          redirect_pc_d    = mtvec_q & ALIGN_MASK;
        end else begin
          state_d       = ST_WR;
          old_d         = rd_val;
          legal_d       = rd_legal;
          csr_ack_d     = 1'b1;
          csr_illegal_d = ~rd_legal;
          csr_rdata_d   = rd_legal ? rd_val : '0;
        end
      end

      ST_WR: begin
        state_d = ST_IDLE;
        if (do_write) begin
          case (addr_q)
            ADDR_MSTATUS: begin
              mie_d  = wr_val[3];
              mpie_d = wr_val[7];
            end
            ADDR_MTVEC:    mtvec_d    = wr_val & ALIGN_MASK;
            ADDR_MSCRATCH: mscratch_d = wr_val;
            ADDR_MEPC:     mepc_d     = wr_val & ALIGN_MASK;
            ADDR_MCAUSE:   mcause_d   = wr_val;
`ifdef RISCV_CSR_MCYCLE_EN
            // Writing a half replaces it and drops this cycle's increment
            ADDR_MCYCLE:   mcycle_d   = {mcycle_q[63:32], 32'(wr_val)};
            ADDR_MCYCLEH:  mcycle_d   = {32'(wr_val), mcycle_q[31:0]};
`endif
            default: ;
          endcase
        end
      end

      ST_TRAP: begin
        state_d  = ST_IDLE;
        mepc_d   = trap_pc & ALIGN_MASK;
        mcause_d = trap_cause;
        mpie_d   = mie_q;
        mie_d    = 1'b0;
      end

      ST_RET: begin
        state_d = ST_IDLE;
        mie_d   = mpie_q;
        mpie_d  = 1'b1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      fun_q          <= CSR_NONE;
      wdata_q        <= '0;
      old_q          <= '0;
      legal_q        <= 1'b0;
      mie_q          <= 1'b0;
      mpie_q         <= 1'b0;
      mtvec_q        <= MTVEC_RESET;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
`ifdef RISCV_CSR_MCYCLE_EN
      mcycle_q       <= '0;
`endif
      csr_ack        <= 1'b0;
      csr_rdata      <= '0;
      csr_illegal    <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      fun_q          <= fun_d;
      wdata_q        <= wdata_d;
      old_q          <= old_d;
      legal_q        <= legal_d;
      mie_q          <= mie_d;
      mpie_q         <= mpie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
`ifdef RISCV_CSR_MCYCLE_EN
      mcycle_q       <= mcycle_d;
`endif
      csr_ack        <= csr_ack_d;
      csr_rdata      <= csr_rdata_d;
      csr_illegal    <= csr_illegal_d;
      redirect_valid <= redirect_valid_d;
      redirect_pc    <= redirect_pc_d;
    end
  end

endmodule
